// File: rtl/tc_timer_pkg.sv
// tc_timer_pkg: register offsets, CTRL fields, MODE codes and FSM states for tc_timer,
// shared with the CPU-side bridge decode.
package tc_timer_pkg;
    localparam logic [1:0] REG_CTRL   = 2'd0;
    localparam logic [1:0] REG_PRESET = 2'd1;
    localparam logic [1:0] REG_COUNT  = 2'd2;
    localparam logic [1:0] REG_PSC    = 2'd3;
    localparam int CTRL_EN   = 0;
    localparam int CTRL_MODE = 1;
    localparam int CTRL_IM   = 3;
    localparam logic [1:0] MODE_ONESHOT = 2'b00;
    localparam logic [1:0] MODE_AUTO    = 2'b01;
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_LOAD = 2'd1, S_CNT = 2'd2, S_INT = 2'd3} state_e;
    // MODE 1x falls back to one-shot, so only the exact auto code reloads
    function automatic logic is_auto(input logic [1:0] mode);
        return mode == MODE_AUTO;
    endfunction
endpackage

// File: rtl/tc_timer.sv
// tc_timer: CPU-mapped countdown timer, one-shot/auto-reload, masked irq.
// Defining TC_PRESCALE_EN adds a 16-bit prescaler register at 0xC.
module tc_timer
    import tc_timer_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] addr,
    input  logic        we,
    input  logic [31:0] din,
    output logic [31:0] dout,
    output logic        irq
);
    state_e      state_q;
    logic [3:0]  ctrl_q;
    logic [31:0] preset_q;
    logic [31:0] count_q;
    logic        flag_q;
    logic [1:0]  sel;
    logic        en;
    logic        tick;
    logic        expire;
    logic        wr_ctrl;
    logic [31:0] psc_rd;
    logic        unused_addr;

    assign sel         = addr[3:2];
    assign en          = ctrl_q[CTRL_EN];
    assign wr_ctrl     = we && sel == REG_CTRL;
    assign expire      = state_q == S_CNT && en && tick && count_q <= 32'd1;
    assign unused_addr = ^{addr[31:4], addr[1:0]};

`ifdef TC_PRESCALE_EN
    logic [15:0] psc_q;
    logic [15:0] div_q;
    assign tick   = div_q == psc_q;
    assign psc_rd = {16'd0, psc_q};
    always_ff @(posedge clk) begin
        if (reset) begin
            psc_q <= '0;
            div_q <= '0;
        end else begin
            if (state_q == S_LOAD)
                div_q <= '0;
            else if (state_q == S_CNT && en)
                div_q <= tick ? 16'd0 : div_q + 16'd1;
            if (we && sel == REG_PSC)
                psc_q <= din[15:0];
        end
    end
`else
    assign tick   = 1'b1;
    assign psc_rd = '0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            ctrl_q   <= '0;
            preset_q <= '0;
            count_q  <= '0;
            flag_q   <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: if (en) state_q <= S_LOAD;
                S_LOAD: begin
                    count_q <= preset_q;
                    state_q <= S_CNT;
                end
                S_CNT: begin
                    if (!en)
                        state_q <= S_IDLE;
                    else if (expire) begin
                        count_q <= '0;
                        flag_q  <= 1'b1;
                        state_q <= S_INT;
                    end else if (tick)
                        count_q <= count_q - 32'd1;
                end
                S_INT: begin
                    if (is_auto(ctrl_q[CTRL_MODE +: 2])) begin
                        flag_q  <= 1'b0;
                        state_q <= S_LOAD;
                    end else begin
                        ctrl_q[CTRL_EN] <= 1'b0;
                        state_q         <= S_IDLE;
                    end
                end
            endcase
            // CPU CTRL write beats the FSM's EN clear; a same-edge expiry still sets the flag
            if (wr_ctrl) begin
                ctrl_q <= din[3:0];
                if (!expire) flag_q <= 1'b0;
            end
            if (we && sel == REG_PRESET)
                preset_q <= din;
        end
    end

    assign dout = sel == REG_CTRL   ? {28'd0, ctrl_q} :
                  sel == REG_PRESET ? preset_q :
                  sel == REG_COUNT  ? count_q : psc_rd;
    assign irq  = flag_q & ctrl_q[CTRL_IM];
endmodule

// File: tb/tb_tc_timer.sv
// tb_tc_timer: vector table, directed corner sequences and random traffic against a reference model.
module tb_tc_timer;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        we = 1'b0;
    logic [31:0] addr = '0;
    logic [31:0] din = '0;
    logic [31:0] dout;
    logic        irq;
    int total = 0;
    int bad = 0;

    tc_timer dut (.clk(clk), .reset(reset), .addr(addr), .we(we), .din(din), .dout(dout), .irq(irq));

    always #5 clk = ~clk;

`ifdef TC_PRESCALE_EN
    localparam logic [31:0] PSC_EXP = 32'h0000ABCD;
`else
    localparam logic [31:0] PSC_EXP = 32'h0;
`endif

    // Reference model; phase: 0 stopped, 1 reload pending, 2 counting, 3 just expired
    logic [3:0]  m_ctrl = '0;
    logic [31:0] m_preset = '0;
    logic [31:0] m_count = '0;
    logic        m_flag = 1'b0;
    logic [15:0] m_psc = '0;
    logic [15:0] m_div = '0;
    int          m_phase = 0;

    task automatic model_edge();
        logic [3:0] c;
        logic expire;
        logic step;
        c = m_ctrl;
        expire = 1'b0;
`ifdef TC_PRESCALE_EN
        step = m_div == m_psc;
`else
        step = 1'b1;
`endif
        if (reset) begin
            m_ctrl = '0; m_preset = '0; m_count = '0; m_flag = 1'b0;
            m_psc = '0; m_div = '0; m_phase = 0;
        end else begin
            if (m_phase == 0) begin
                if (c[0]) m_phase = 1;
            end else if (m_phase == 1) begin
                m_count = m_preset;
                m_div = '0;
                m_phase = 2;
            end else if (m_phase == 2) begin
                if (!c[0]) m_phase = 0;
                else if (!step) m_div = m_div + 16'd1;
                else begin
                    m_div = '0;
                    if (m_count > 1) m_count = m_count - 1;
                    else begin
                        m_count = 0;
                        expire = 1'b1;
                        m_phase = 3;
                    end
                end
            end else begin
                if (c[2:1] == 2'b01) begin
                    m_flag = 1'b0;
                    m_phase = 1;
                end else begin
                    m_ctrl[0] = 1'b0;
                    m_phase = 0;
                end
            end
            if (we && addr[3:2] == 2'd0) begin
                m_ctrl = din[3:0];
                m_flag = 1'b0;
            end
            if (we && addr[3:2] == 2'd1) m_preset = din;
`ifdef TC_PRESCALE_EN
            if (we && addr[3:2] == 2'd3) m_psc = din[15:0];
`endif
            if (expire) m_flag = 1'b1;
        end
    endtask

    function automatic logic [31:0] exp_read(input int k);
        return k == 0 ? {28'd0, m_ctrl} : k == 1 ? m_preset : k == 2 ? m_count : {16'd0, m_psc};
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d);
        reset = r; we = w; addr = a; din = d;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        drive(1'b0, 1'b1, a, d);
        tick();
        we = 1'b0;
    endtask

    task automatic rd(input string name, input logic [31:0] a, input logic [31:0] exp);
        addr = a;
        #1;
        chk(name, dout, exp);
    endtask

    task automatic do_reset();
        drive(1'b1, 1'b0, 32'h0, 32'h0);
        tick();
        reset = 1'b0;
    endtask

    typedef struct {
        logic        rst;
        logic        w;
        logic [31:0] waddr;
        logic [31:0] wdata;
        logic [31:0] raddr;
        logic [31:0] exp_dout;
        logic        exp_irq;
    } vec_t;

    vec_t tv [17];
    logic [31:0] ce [10];

    initial begin
        tv[0]  = '{1'b1, 1'b0, 32'h0, 32'h0,      32'h0,        32'h0,   1'b0};
        tv[1]  = '{1'b0, 1'b1, 32'h4, 32'h5,      32'h4,        32'h5,   1'b0};
        tv[2]  = '{1'b0, 1'b0, 32'h0, 32'h0,      32'hABCD0017, 32'h5,   1'b0};
        tv[3]  = '{1'b0, 1'b1, 32'h0, 32'h9,      32'h0,        32'h9,   1'b0};
        tv[4]  = '{1'b0, 1'b0, 32'h0, 32'h0,      32'h8,        32'h0,   1'b0};
        tv[5]  = '{1'b0, 1'b0, 32'h0, 32'h0,      32'h8,        32'h5,   1'b0};
        tv[6]  = '{1'b0, 1'b0, 32'h0, 32'h0,      32'h8,        32'h4,   1'b0};
        tv[7]  = '{1'b0, 1'b0, 32'h0, 32'h0,      32'h8,        32'h3,   1'b0};
        tv[8]  = '{1'b0, 1'b0, 32'h0, 32'h0,      32'h8,        32'h2,   1'b0};
        tv[9]  = '{1'b0, 1'b0, 32'h0, 32'h0,      32'h8,        32'h1,   1'b0};
        tv[10] = '{1'b0, 1'b0, 32'h0, 32'h0,      32'h8,        32'h0,   1'b1};
        tv[11] = '{1'b0, 1'b0, 32'h0, 32'h0,      32'h0,        32'h8,   1'b1};
        tv[12] = '{1'b0, 1'b1, 32'h8, 32'h1234,   32'h8,        32'h0,   1'b1};
        tv[13] = '{1'b0, 1'b1, 32'hC, 32'hABCD,   32'hC,        PSC_EXP, 1'b1};
        tv[14] = '{1'b0, 1'b1, 32'h0, 32'h8,      32'h0,        32'h8,   1'b0};
        tv[15] = '{1'b1, 1'b1, 32'h0, 32'hF,      32'h0,        32'h0,   1'b0};
        tv[16] = '{1'b0, 1'b0, 32'h0, 32'h0,      32'h4,        32'h0,   1'b0};
        ce = '{32'd0, 32'd3, 32'd2, 32'd1, 32'd0, 32'd0, 32'd3, 32'd2, 32'd1, 32'd0};

        // One-shot walk-through, read-only COUNT, 0xC decode, reset beating a write
        for (int i = 0; i < 17; i++) begin
            drive(tv[i].rst, tv[i].w, tv[i].waddr, tv[i].wdata);
            tick();
            reset = 1'b0;
            we = 1'b0;
            rd($sformatf("vec%0d_dout", i), tv[i].raddr, tv[i].exp_dout);
            chk($sformatf("vec%0d_irq", i), {31'd0, irq}, {31'd0, tv[i].exp_irq});
        end

        // Auto-reload: one-cycle pulses every PRESET+2 cycles
        do_reset();
        wr(32'h4, 32'd3);
        wr(32'h0, 32'hB);
        for (int e = 1; e <= 16; e++) begin
            tick();
            chk($sformatf("auto_irq_e%0d", e), {31'd0, irq}, {31'd0, e == 5 || e == 10 || e == 15});
            if (e <= 10) rd($sformatf("auto_count_e%0d", e), 32'h8, ce[e-1]);
        end

        // Masked expiry: flag hidden, CTRL write clears it, restart fires at edge 27
        do_reset();
        wr(32'h4, 32'd10);
        wr(32'h0, 32'h1);
        for (int e = 1; e <= 14; e++) begin
            tick();
            chk($sformatf("mask_irq_e%0d", e), {31'd0, irq}, 32'd0);
            if (e == 12) rd("mask_count_e12", 32'h8, 32'd0);
            if (e == 13) rd("mask_ctrl_e13", 32'h0, 32'd0);
        end
        wr(32'h0, 32'h9);
        chk("mask_irq_e15", {31'd0, irq}, 32'd0);
        for (int e = 16; e <= 28; e++) begin
            tick();
            chk($sformatf("mask_rearm_irq_e%0d", e), {31'd0, irq}, {31'd0, e >= 27});
        end

        // Stop mid-count: COUNT freezes at 3
        do_reset();
        wr(32'h4, 32'd10);
        wr(32'h0, 32'h9);
        for (int e = 1; e <= 8; e++) tick();
        rd("stop_count_before", 32'h8, 32'd4);
        wr(32'h0, 32'h0);
        rd("stop_count_e9", 32'h8, 32'd3);
        for (int e = 10; e <= 13; e++) begin
            tick();
            rd($sformatf("stop_count_e%0d", e), 32'h8, 32'd3);
            chk($sformatf("stop_irq_e%0d", e), {31'd0, irq}, 32'd0);
        end

        // Reset mid-count with a simultaneous CTRL write
        do_reset();
        wr(32'h4, 32'd20);
        wr(32'h0, 32'h9);
        for (int e = 1; e <= 5; e++) tick();
        drive(1'b1, 1'b1, 32'h0, 32'hF);
        tick();
        reset = 1'b0;
        we = 1'b0;
        for (int k = 0; k < 4; k++) rd($sformatf("rst_reg%0d", k), 32'(k * 4), 32'd0);
        chk("rst_irq", {31'd0, irq}, 32'd0);
        for (int e = 0; e < 4; e++) begin
            tick();
            rd($sformatf("rst_idle_count%0d", e), 32'h8, 32'd0);
            chk($sformatf("rst_idle_irq%0d", e), {31'd0, irq}, 32'd0);
        end

        // PRESET=0 expires like PRESET=1
        do_reset();
        wr(32'h4, 32'd0);
        wr(32'h0, 32'h9);
        for (int e = 1; e <= 4; e++) begin
            tick();
            chk($sformatf("p0_irq_e%0d", e), {31'd0, irq}, {31'd0, e >= 3});
        end

        // PRESET rewritten mid-count only applies at the next reload
        do_reset();
        wr(32'h4, 32'd3);
        wr(32'h0, 32'hB);
        for (int e = 1; e <= 14; e++) begin
            if (e == 3) drive(1'b0, 1'b1, 32'h4, 32'd6);
            tick();
            we = 1'b0;
            chk($sformatf("prechg_irq_e%0d", e), {31'd0, irq}, {31'd0, e == 5 || e == 13});
        end

        // CPU CTRL write on the one-shot INT edge wins over the EN clear
        do_reset();
        wr(32'h4, 32'd2);
        wr(32'h0, 32'h9);
        for (int e = 1; e <= 10; e++) begin
            if (e == 5) drive(1'b0, 1'b1, 32'h0, 32'h9);
            tick();
            we = 1'b0;
            chk($sformatf("race_irq_e%0d", e), {31'd0, irq}, {31'd0, e == 4 || e >= 9});
            if (e == 5) rd("race_ctrl_e5", 32'h0, 32'h9);
        end

        // Random traffic against the model
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            drive($urandom_range(0, 99) == 0, $urandom_range(0, 5) == 0, $urandom,
                  $urandom_range(0, 7) == 0 ? $urandom : 32'($urandom_range(0, 12)));
            tick();
            reset = 1'b0;
            we = 1'b0;
            for (int k = 0; k < 4; k++)
                rd($sformatf("rnd%0d_reg%0d", i, k), 32'(k * 4), exp_read(k));
            chk($sformatf("rnd%0d_irq", i), {31'd0, irq}, {31'd0, m_flag & m_ctrl[3]});
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/tc_timer.md
TC_TIMER -- requirements
Module: tc_timer

Interface
REQ-001 SHALL have port: clk  input  1  the only clock, rising-edge.
REQ-002 SHALL have port: reset  input  1  synchronous, active-high reset.
REQ-003 SHALL have port: addr  input  32  byte address from the CPU memory stage; only bits [3:2] are decoded.
REQ-004 SHALL have port: we  input  1  write strobe; registers are written on the clk edge when we=1.
REQ-005 SHALL have port: din  input  32  write data.
REQ-006 SHALL have port: dout  output  32  read data for addr, combinational.
REQ-007 SHALL have port: irq  output  1  interrupt request, routed to one HWInt bit of the CPU.
REQ-008 SHALL have parameter: none; the register map is fixed as CTRL=0x0, PRESET=0x4, COUNT=0x8.

Function
REQ-009 CTRL fields SHALL be: [0] EN, [2:1] MODE (00 one-shot, 01 auto-reload, 1x treated as 00), [3] IM (irq mask); bits [31:4] SHALL read 0.
REQ-010 PRESET SHALL be 32-bit read/write; COUNT SHALL be read-only, and writes to COUNT SHALL be ignored.
REQ-011 The FSM SHALL have states IDLE, LOAD, CNT, INT, advancing one state per clk.
REQ-012 IDLE: EN=1 -> LOAD; otherwise stay.
REQ-013 LOAD: COUNT<=PRESET, -> CNT.
REQ-014 CNT: EN=0 -> IDLE with COUNT held; COUNT>1 -> COUNT-1, stay; COUNT<=1 -> COUNT<=0, set the irq flag, -> INT.
REQ-015 INT, MODE 00: CTRL.EN<=0, -> IDLE; the flag SHALL stay set until the next write to CTRL.
REQ-016 INT, MODE 01: the flag SHALL clear on exit, -> LOAD; the flag is therefore high for exactly one cycle per period.
REQ-017 irq SHALL equal flag AND IM.
REQ-018 Latency: PRESET=N>=1 with EN written at cycle t SHALL set the flag at edge t+N+2.
REQ-019 PRESET=0 SHALL behave as PRESET=1.
REQ-020 Auto-reload period SHALL be N+2 cycles.
REQ-021 A CPU write to CTRL in the same cycle as an FSM update of CTRL.EN (INT, MODE 00) SHALL win; the FSM transition itself proceeds on the pre-write CTRL.
REQ-022 A PRESET write during CNT SHALL take effect only at the next LOAD.
REQ-023 A read at addr[3:2]=11 SHALL return 0 unless TC_PRESCALE_EN is defined.

Reset
REQ-024 On reset=1 at a clk edge, all of the following SHALL be 0: CTRL, PRESET, COUNT, the flag, dout-selected registers, and irq; the state SHALL be IDLE.
REQ-025 Reset SHALL override a simultaneous we and abort any count in progress.

Configuration
REQ-026 With TC_PRESCALE_EN defined, a 16-bit read/write PSC register SHALL exist at 0xC (reset 0).
REQ-027 With TC_PRESCALE_EN defined, CNT SHALL decrement COUNT only once every PSC+1 cycles, using an internal divider cleared in LOAD.
REQ-028 Without TC_PRESCALE_EN, 0xC SHALL read 0, ignore writes, and COUNT SHALL decrement every cycle.

Structure
REQ-029 A shared package SHALL hold the register offsets, CTRL bit positions, MODE encodings and the FSM state encoding, for reuse by the CPU-side bridge decode.
REQ-030 The design SHALL be a single module with no sub-modules; the optional prescaler stays inline under the macro.

Verification
REQ-031 PRESET=5, CTRL=0x9 written at cycle 0 -> flag and irq rise at edge 7 and stay high; CTRL.EN reads 0; a CTRL write of 0x8 drops irq the next cycle.
REQ-032 PRESET=3, CTRL=0xB -> irq pulses one cycle wide at edges 5, 10, 15; COUNT sequence reads 3,2,1,0,...
REQ-033 PRESET=10, CTRL=0x1 (IM=0) -> flag sets at edge 12 but irq stays 0; a later write of CTRL=0x9 clears the flag, and irq stays 0.
REQ-034 During CNT with COUNT=4, write CTRL=0 -> state IDLE next cycle, COUNT holds 3, no irq.
REQ-035 Mid-count reset=1 together with we=1, din=0xF to CTRL -> all registers read 0 the next cycle, and irq=0.
REQ-036 Write 0x1234 to COUNT, and read addr 0xC -> COUNT unchanged; 0xC reads 0 (or PSC value when TC_PRESCALE_EN is defined).
